digit_frame_ctrl: RTL and testbench
===================================

# digit_frame_ctrl

Time-keeping and edit controller that produces the 16-bit four-digit BCD bus consumed by the VGA digit renderer, displayed as HH:MM with the colon glyph. It keeps a 24-hour clock from a clock-rate prescaler and runs a two-button set-mode state machine with blinking of the selected field. The display bus is reloaded only at the start of the vertical sync pulse, so a frame never shows a half-updated value.

## Interface
- CLK_HZ, 25_000_000, clk frequency. Sets the 1 s prescaler and the blink period. Benches override it with a small value.
- clk  in  1  system/pixel clock, same clock as vga_sync.
- reset  in  1  synchronous, active-high.
- vsync  in  1  vga_sync vertical sync, active-low.
- btn_mode  in  1  one-cycle pulse, debounced upstream. Advances the edit mode.
- btn_inc  in  1  one-cycle pulse, debounced upstream. Increments the selected field.
- numeros  out  16  display digits:
  - [3:0] hour tens (leftmost)
  - [7:4] hour units
  - [11:8] minute tens
  - [15:12] minute units
- edit_mode  out  2  current state encoding, for LEDs.

## Operation
- Internal time is BCD HH:MM:SS, plus a prescaler counting 0..CLK_HZ-1. A one-cycle tick is generated when the prescaler wraps.
- State machine (2-bit): RUN=0, SET_HR=1, SET_MIN=2.
  - btn_mode transitions: RUN→SET_HR→SET_MIN→RUN.
  - Reset state is RUN.
- RUN:
  - Each tick increments seconds.
  - Carry chain: SS 59→00 carries into MM; MM 59→00 carries into HH; HH 23→00.
  - 23:59:59 + tick gives 00:00:00.
- SET_HR and SET_MIN:
  - Prescaler and seconds are held at 0.
  - btn_inc increments only the selected field, with wrap and no carry: HH 23→00, MM 59→00.
- Leaving SET_MIN for RUN: seconds=0, prescaler=0, so the first tick arrives CLK_HZ cycles later.
- Blink:
  - A counter toggles the blink phase every CLK_HZ/4 cycles.
  - On entering SET_HR or SET_MIN, and on every btn_inc, the blink counter clears and the phase is forced to visible.
  - During the hidden phase, both digits of the selected field are driven as 4'hF.
  - 4'hF is the blank code; the renderer draws no segments for it.
  - RUN never blanks.
- Shadow word: a 16-bit register built every cycle from the time, state and blink phase.
- numeros loads from the shadow word only on a vsync falling edge. Edge detect uses a registered vsync_q: fall = vsync_q & ~vsync.
- Simultaneous events:
  - btn_mode with btn_inc in the same cycle: mode wins, inc is ignored.
  - btn_mode in RUN in the same cycle as a tick: the tick is dropped and the state enters SET_HR.
  - Tick and vsync fall in the same cycle: numeros takes the pre-tick value, and the new value appears on the next frame.

## Timing
- Reset values:
  - numeros=16'h0000, edit_mode=0.
  - Time 00:00:00, prescaler=0, blink phase visible.
  - vsync_q=1, so no spurious edge on release.
- Reset mid-edit returns to RUN at 00:00 on the next clock edge.
- numeros changes on the first clk edge at which vsync is sampled 0 after being sampled 1. Otherwise numeros is stable for the whole frame.
- Button effects land in internal state 1 cycle after the pulse. They become visible at the next vsync fall.
- edit_mode is registered and changes 1 cycle after btn_mode.
- Prescaler width is $clog2(CLK_HZ). The blink counter is sized to CLK_HZ/4; CLK_HZ must be ≥4.

## Structure
- Shared package holds:
  - state encoding RUN/SET_HR/SET_MIN
  - BLANK_DIGIT=4'hF and COLON_DIGIT=4'hA
  - digit nibble positions for numeros
- Sub-module bcd_wrap_counter:
  - two-digit BCD counter, parameter MAX (23 or 59)
  - inputs: inc, clr
  - outputs: tens, units, carry
  - used three times: SS, MM, HH
- FSM, prescaler, blink and frame latch stay in the top module.

## Test plan
- Reset, then toggle vsync (period 50 cycles, low 5) → numeros=16'h0000 after the first fall, edit_mode=0; no change while vsync is held high.
- CLK_HZ=8, run 60×8 cycles in RUN → after the next vsync fall, numeros=16'h1000 (00:01).
- Set 23:59 via SET_HR ×23 inc and SET_MIN ×59 inc, return to RUN, run 60×8 cycles → numeros=16'h0000.
- SET_HR, then btn_inc ×25 → hours=01 (wrap at 24); during the hidden phase, numeros[7:0]=8'hFF while minutes stay visible. Pressing btn_inc and btn_mode together → state goes to SET_MIN and hours stay 01.
- Change time while vsync=1 → numeros holds; it updates exactly 1 cycle after vsync is first sampled low.
- Assert reset during SET_MIN with time 12:34 → next cycle edit_mode=0; numeros=16'h0000 at reset and after the next vsync fall.

Source files
------------

// File: rtl/digit_frame_ctrl_pkg.sv
// Shared definitions for the HH:MM frame controller: edit-state encoding,
// special digit codes, and where each digit sits inside the numeros bus.
// No logic, no latency, no flow control.
package digit_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } edit_state_e;

  // Digit codes understood by the renderer.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [3:0] COLON_DIGIT = 4'hA;

  // Nibble positions inside numeros (hour tens is the leftmost glyph).
  localparam int HR_TENS_LSB   = 0;
  localparam int HR_UNITS_LSB  = 4;
  localparam int MIN_TENS_LSB  = 8;
  localparam int MIN_UNITS_LSB = 12;

  function automatic logic [15:0] pack_digits(input logic [3:0] hr_tens,
                                              input logic [3:0] hr_units,
                                              input logic [3:0] min_tens,
                                              input logic [3:0] min_units);
    logic [15:0] word;
    word = '0;
    word[HR_TENS_LSB   +: 4] = hr_tens;
    word[HR_UNITS_LSB  +: 4] = hr_units;
    word[MIN_TENS_LSB  +: 4] = min_tens;
    word[MIN_UNITS_LSB +: 4] = min_units;
    return word;
  endfunction

endpackage

// File: rtl/digit_frame_ctrl_if.sv
// Bundle between the frame controller and its surroundings: vsync and the
// two debounced button pulses in, the display digits and edit state out.
// Ports: vsync (active-low), btn_mode, btn_inc, numeros[15:0], edit_mode[1:0].
interface digit_frame_ctrl_if;

  logic        vsync;
  logic        btn_mode;
  logic        btn_inc;
  logic [15:0] numeros;
  logic [1:0]  edit_mode;

  // master drives the sync and buttons (board/bench side)
  modport master (
    output vsync, btn_mode, btn_inc,
    input  numeros, edit_mode
  );

  // slave is the controller itself
  modport slave (
    input  vsync, btn_mode, btn_inc,
    output numeros, edit_mode
  );

endinterface

// File: rtl/digit_frame_ctrl_bcd_wrap_counter.sv
// Two-digit BCD counter wrapping from MAX back to 00 (MAX = 23 or 59).
// Count lands one clk after inc_i; carry_o is combinational with inc_i.
// Ports: clk, reset, inc_i, clr_i (wins over inc_i), tens_o, units_o, carry_o.
module bcd_wrap_counter #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       carry_o
);

  localparam logic [3:0] MAX_TENS  = 4'(MAX / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_max;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    carry_o = inc_i && at_max && !clr_i;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/digit_frame_ctrl.sv
// 24-hour HH:MM keeper with two-button set mode and blinking edit field;
// button effects land 1 clk after the pulse, numeros reloads at vsync fall.
// Ports: clk, reset (sync, active-high), bus (slave: vsync, btn_mode,
// btn_inc in; numeros, edit_mode out). No backpressure: pulses always taken.
module digit_frame_ctrl
  import digit_frame_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  digit_frame_ctrl_if.slave bus
);

  localparam int             PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
  localparam int             BLINK_DIV  = CLK_HZ / 4;
  localparam int             BW         = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);

  edit_state_e   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_vis_q, blink_vis_d;
  logic          vsync_q;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   numeros_q;

  logic in_run, run_tick, inc_hit, blink_clr, vsync_fall;
  logic sec_clr, min_inc, hr_inc;
  logic sec_carry, min_carry, hr_carry_unused;
  logic [3:0] sec_tens_unused, sec_units_unused;
  logic [3:0] min_tens, min_units, hr_tens, hr_units;
  logic [3:0] disp_hr_tens, disp_hr_units, disp_min_tens, disp_min_units;

  // ---------------------------------------------------------------------
  // Next-state: FSM, prescaler, field increments, blink, shadow word.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;

    in_run = (state_q == RUN);

    if (bus.btn_mode) begin
      unique case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        default: state_d = RUN;
      endcase
    end

    // A mode press in RUN steals the tick of the same cycle; the
    // prescaler is parked at 0 whenever the clock is not running.
    run_tick = in_run && !bus.btn_mode && (presc_q == PRESC_LAST);
    if (in_run && !bus.btn_mode && (presc_q != PRESC_LAST)) begin
      presc_d = presc_q + 1'b1;
    end

    // Mode has priority over increment when both arrive together.
    inc_hit = bus.btn_inc && !bus.btn_mode && !in_run;

    // Seconds stay at 0 in set mode and on the way into it.
    sec_clr = !in_run || bus.btn_mode;
    min_inc = sec_carry || (inc_hit && (state_q == SET_MIN));
    // Minute wrap carries into hours only while running.
    hr_inc  = (min_carry && in_run) || (inc_hit && (state_q == SET_HR));

    // Any mode change or accepted increment restarts a visible half-period,
    // so the field being edited is shown right after the press.
    blink_clr = in_run || bus.btn_mode || inc_hit;
    if (blink_clr) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_vis_d = !blink_vis_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    disp_hr_tens   = hr_tens;
    disp_hr_units  = hr_units;
    disp_min_tens  = min_tens;
    disp_min_units = min_units;
    if (!blink_vis_q && (state_q == SET_HR)) begin
      disp_hr_tens  = BLANK_DIGIT;
      disp_hr_units = BLANK_DIGIT;
    end
    if (!blink_vis_q && (state_q == SET_MIN)) begin
      disp_min_tens  = BLANK_DIGIT;
      disp_min_units = BLANK_DIGIT;
    end
    shadow_d = pack_digits(disp_hr_tens, disp_hr_units,
                           disp_min_tens, disp_min_units);

    vsync_fall = vsync_q && !bus.vsync;
  end

  // ---------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      vsync_q     <= 1'b1;   // released high so no fake edge after reset
      shadow_q    <= '0;
      numeros_q   <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      vsync_q     <= bus.vsync;
      shadow_q    <= shadow_d;
      // Frame latch: the renderer sees one consistent word per frame.
      if (vsync_fall) begin
        numeros_q <= shadow_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Time-of-day counters: SS -> MM -> HH.
  // ---------------------------------------------------------------------
  bcd_wrap_counter #(.MAX(59)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (run_tick),
    .clr_i   (sec_clr),
    .tens_o  (sec_tens_unused),
    .units_o (sec_units_unused),
    .carry_o (sec_carry)
  );

  bcd_wrap_counter #(.MAX(59)) u_min (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (min_inc),
    .clr_i   (1'b0),
    .tens_o  (min_tens),
    .units_o (min_units),
    .carry_o (min_carry)
  );

  // Day rollover has no consumer; the hour counter just wraps.
  bcd_wrap_counter #(.MAX(23)) u_hr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (hr_inc),
    .clr_i   (1'b0),
    .tens_o  (hr_tens),
    .units_o (hr_units),
    .carry_o (hr_carry_unused)
  );

  assign bus.numeros   = numeros_q;
  assign bus.edit_mode = state_q;

endmodule

// File: tb/tb_digit_frame_ctrl.sv
// Self-checking bench for digit_frame_ctrl: directed scenarios plus a
// randomized run, all compared every cycle against a time-of-day model.
module tb_digit_frame_ctrl;

  localparam int HZ  = 8;
  localparam int DIV = HZ / 4;

  logic clk = 1'b0;
  logic reset;

  digit_frame_ctrl_if ifc ();

  digit_frame_ctrl #(.CLK_HZ(HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit vs_free  = 1'b0;

  // Model state: plain integers for time, mode, blink and frame latch.
  int          m_state, m_hh, m_mm, m_ss, m_presc, m_bcnt;
  bit          m_vis, m_vsq;
  logic [15:0] m_shadow, m_num;

  function automatic logic [15:0] disp_word(int st, int hh, int mm, bit vis);
    logic [3:0] ht, hu, mt, mu;
    ht = 4'(hh / 10); hu = 4'(hh % 10);
    mt = 4'(mm / 10); mu = 4'(mm % 10);
    if (!vis && st == 1) begin ht = 4'hF; hu = 4'hF; end
    if (!vis && st == 2) begin mt = 4'hF; mu = 4'hF; end
    return {mu, mt, hu, ht};
  endfunction

  task automatic check_eq(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int  ost, t;
    bit  bm, bi, vs;
    logic [15:0] nsh;
    bm = ifc.btn_mode; bi = ifc.btn_inc; vs = ifc.vsync;
    if (reset) begin
      m_state = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_bcnt = 0;
      m_vis = 1; m_vsq = 1; m_shadow = '0; m_num = '0;
      return;
    end
    nsh = disp_word(m_state, m_hh, m_mm, m_vis);
    if (m_vsq && !vs) m_num = m_shadow;
    m_vsq    = vs;
    m_shadow = nsh;
    ost = m_state;
    case (ost)
      0: begin
        if (bm) begin
          m_state = 1; m_ss = 0; m_presc = 0;
        end else if (m_presc == HZ - 1) begin
          m_presc = 0;
          t = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
          m_hh = t / 3600; m_mm = (t / 60) % 60; m_ss = t % 60;
        end else begin
          m_presc++;
        end
      end
      1: begin
        m_ss = 0; m_presc = 0;
        if (bm) m_state = 2;
        else if (bi) m_hh = (m_hh + 1) % 24;
      end
      default: begin
        m_ss = 0; m_presc = 0;
        if (bm) m_state = 0;
        else if (bi) m_mm = (m_mm + 1) % 60;
      end
    endcase
    if (ost == 0 || bm || bi) begin
      m_bcnt = 0; m_vis = 1;
    end else if (m_bcnt == DIV - 1) begin
      m_bcnt = 0; m_vis = !m_vis;
    end else begin
      m_bcnt++;
    end
  endtask

  // One clock: predict, clock, then compare outputs 1 time unit later.
  task automatic cycle();
    if (vs_free) ifc.vsync = ((cyc % 50) < 5) ? 1'b0 : 1'b1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("numeros", ifc.numeros, m_num);
    check_eq("edit_mode", {14'b0, ifc.edit_mode}, 16'(m_state));
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic press(bit bm, bit bi);
    ifc.btn_mode = bm;
    ifc.btn_inc  = bi;
    cycle();
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    repeat ($urandom_range(2, 0)) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    bit seen_h, seen_v;
    reset        = 1'b1;
    ifc.vsync    = 1'b1;
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;

    // Reset state and frame behaviour with vsync held, then toggling.
    do_reset();
    check_eq("reset_numeros", ifc.numeros, 16'h0000);
    check_eq("reset_edit", {14'b0, ifc.edit_mode}, 16'h0000);
    idle(30);
    check_eq("vsync_high_hold", ifc.numeros, 16'h0000);
    vs_free = 1'b1;
    idle(60);
    check_eq("first_frame", ifc.numeros, 16'h0000);

    // One minute of ticks in RUN.
    do_reset();
    idle(480);
    idle(60);
    check_eq("one_minute", ifc.numeros, 16'h1000);

    // Set 23:59, run a minute, expect midnight.
    do_reset();
    press(1, 0);
    repeat (23) press(0, 1);
    press(1, 0);
    repeat (59) press(0, 1);
    press(1, 0);
    check_eq("back_to_run", {14'b0, ifc.edit_mode}, 16'h0000);
    idle(60);
    check_eq("set_2359", ifc.numeros, 16'h9532);
    idle(420);
    idle(60);
    check_eq("midnight_wrap", ifc.numeros, 16'h0000);

    // Hour wrap after 25 increments, blinking, mode beats inc.
    do_reset();
    press(1, 0);
    check_eq("enter_set_hr", {14'b0, ifc.edit_mode}, 16'h0001);
    repeat (25) press(0, 1);
    vs_free   = 1'b0;
    ifc.vsync = 1'b1;
    seen_h = 0; seen_v = 0;
    for (int i = 0; i < 12; i++) begin
      ifc.vsync = ~ifc.vsync;
      cycle();
      if (ifc.numeros == 16'h00FF) seen_h = 1;
      if (ifc.numeros == 16'h0010) seen_v = 1;
    end
    check_eq("blink_hidden_seen", {15'b0, seen_h}, 16'h0001);
    check_eq("blink_visible_seen", {15'b0, seen_v}, 16'h0001);
    ifc.vsync = 1'b1;
    vs_free   = 1'b1;
    press(1, 1);
    check_eq("mode_beats_inc", {14'b0, ifc.edit_mode}, 16'h0002);
    idle(60);
    check_eq("hours_kept", {8'h00, ifc.numeros[7:0]}, 16'h0010);

    // numeros frozen while vsync stays high, updates on the falling edge.
    vs_free   = 1'b0;
    ifc.vsync = 1'b1;
    do_reset();
    press(1, 0);
    repeat (3) press(0, 1);
    press(1, 0);
    press(1, 0);
    idle(5);
    check_eq("frame_hold", ifc.numeros, 16'h0000);
    ifc.vsync = 1'b0;
    cycle();
    check_eq("update_on_fall", ifc.numeros, 16'h0030);
    ifc.vsync = 1'b1;
    idle(3);

    // Reset in the middle of editing 12:34.
    vs_free = 1'b1;
    do_reset();
    press(1, 0);
    repeat (12) press(0, 1);
    press(1, 0);
    repeat (34) press(0, 1);
    check_eq("in_set_min", {14'b0, ifc.edit_mode}, 16'h0002);
    reset = 1'b1;
    cycle();
    check_eq("mid_edit_reset_edit", {14'b0, ifc.edit_mode}, 16'h0000);
    check_eq("mid_edit_reset_num", ifc.numeros, 16'h0000);
    reset = 1'b0;
    idle(60);
    check_eq("after_reset_frame", ifc.numeros, 16'h0000);

    // Randomized buttons, occasional resets, free-running vsync.
    for (int i = 0; i < 3000; i++) begin
      ifc.btn_mode = ($urandom_range(39, 0) == 0);
      ifc.btn_inc  = ($urandom_range(5, 0) == 0);
      reset        = ($urandom_range(499, 0) == 0);
      cycle();
    end
    reset        = 1'b0;
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
